// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator.
// Holds FSM encoding, decoded raster flags, VESA presets and the colour-bar helper.
package video_timing_pkg;

  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  typedef struct packed {
    logic active;
    logic origin;
    logic hsync_act;
    logic vsync_act;
  } raster_t;

  // 640x480@60
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam bit VGA_HSYNC_POL = 1'b0;
  localparam bit VGA_VSYNC_POL = 1'b0;

  // 1280x720@60
  localparam int HD_H_VISIBLE = 1280;
  localparam int HD_H_FRONT   = 110;
  localparam int HD_H_SYNC    = 40;
  localparam int HD_H_BACK    = 220;
  localparam int HD_V_VISIBLE = 720;
  localparam int HD_V_FRONT   = 5;
  localparam int HD_V_SYNC    = 5;
  localparam int HD_V_BACK    = 20;
  localparam bit HD_HSYNC_POL = 1'b1;
  localparam bit HD_VSYNC_POL = 1'b1;

  // Which of the eight vertical bars column h falls into.
  function automatic logic [2:0] bar_index(input cnt_t h, input int h_visible);
    logic [31:0] scaled;
    scaled = {17'd0, h, 3'd0};
    return 3'(scaled / 32'(h_visible));
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel stream between an upstream source and the timing generator.
// Carries 24-bit RGB words with a start-of-frame tag under valid/ready.
interface video_timing_gen_if;
  logic [23:0] data;
  logic        sof;
  logic        valid;
  logic        ready;

  modport master (output data, output sof, output valid, input ready);
  modport slave  (input data, input sof, input valid, output ready);
endinterface

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with active-area and sync-window decode.
// With VIDEO_TIMING_PATTERN_EN defined it also reports the colour-bar index.
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
`ifdef VIDEO_TIMING_PATTERN_EN
  output logic [2:0] bar_idx,
`endif
  output raster_t    raster
);

  localparam cnt_t H_LAST     = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t H_ACT_END  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_ACT_END  = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_START   = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_END     = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t VS_START   = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_END     = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  cnt_t h_cnt_reg, h_cnt_next;
  cnt_t v_cnt_reg, v_cnt_next;

  // Disabling parks the raster at the origin so re-enabling starts at pixel (0,0).
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (!enable) begin
      h_cnt_next = '0;
      v_cnt_next = '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_next = h_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // vsync decodes on v only, so it changes exactly when h wraps to 0.
  assign raster.active    = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
  assign raster.origin    = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign raster.hsync_act = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
  assign raster.vsync_act = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);

`ifdef VIDEO_TIMING_PATTERN_EN
  assign bar_idx = bar_index(h_cnt_reg, H_VISIBLE);
`endif

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel pacer feeding a DVI transmitter.
// Optional colour-bar source is compiled in with VIDEO_TIMING_PATTERN_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit HSYNC_POL = VGA_HSYNC_POL,
  parameter bit VSYNC_POL = VGA_VSYNC_POL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
`ifdef VIDEO_TIMING_PATTERN_EN
  input  logic               pattern_sel,
`endif
  video_timing_gen_if.slave  s,
  output logic               out_vsync,
  output logic               out_hsync,
  output logic               out_de,
  output logic [23:0]        out_data,
  output logic [3:0]         out_ctl,
  output logic               out_frame_start,
  output logic               status_underflow
);

  raster_t raster;

`ifdef VIDEO_TIMING_PATTERN_EN
  logic [2:0]  bar_idx;
  logic [23:0] bar_data;
`endif

  video_timing_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
`ifdef VIDEO_TIMING_PATTERN_EN
    .bar_idx (bar_idx),
`endif
    .raster  (raster)
  );

`ifdef VIDEO_TIMING_PATTERN_EN
  // Bar index is inverted per channel so bar 0 is white and bar 7 black.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bar
    assign bar_data[gi*8 +: 8] = {8{~bar_idx[gi]}};
  end
`endif

  state_t      state_reg, state_next;
  logic        vsync_reg, vsync_next;
  logic        hsync_reg, hsync_next;
  logic        de_reg, de_next;
  logic [23:0] data_reg, data_next;
  logic        frame_start_reg, frame_start_next;
  logic        underflow_reg, underflow_next;
  logic        stream_ready;

  always_comb begin
    state_next       = state_reg;
    stream_ready     = 1'b0;
    de_next          = 1'b0;
    data_next        = '0;
    frame_start_next = 1'b0;
    underflow_next   = underflow_reg;
    hsync_next       = raster.hsync_act ? HSYNC_POL : ~HSYNC_POL;
    vsync_next       = raster.vsync_act ? VSYNC_POL : ~VSYNC_POL;
    if (!enable) begin
      state_next     = ST_WAIT_SOF;
      underflow_next = 1'b0;
      hsync_next     = ~HSYNC_POL;
      vsync_next     = ~VSYNC_POL;
    end
`ifdef VIDEO_TIMING_PATTERN_EN
    else if (pattern_sel) begin
      state_next = ST_WAIT_SOF;
      de_next    = raster.active;
      if (raster.active) begin
        data_next = bar_data;
      end
    end
`endif
    else begin
      de_next = raster.active;
      case (state_reg)
        // Flush words until an SOF sits at the head, then hold it for the origin.
        ST_WAIT_SOF: begin
          stream_ready = s.valid & (~s.sof | raster.origin);
          if (s.valid && s.sof && raster.origin) begin
            data_next        = s.data;
            frame_start_next = 1'b1;
            state_next       = ST_RUN;
          end
        end
        // A misplaced SOF is refused so it can open the next frame instead.
        ST_RUN: begin
          stream_ready = raster.active & (~s.sof | raster.origin);
          if (raster.active) begin
            if (!s.valid || (s.sof && !raster.origin)) begin
              underflow_next = 1'b1;
              state_next     = ST_WAIT_SOF;
            end else begin
              data_next        = s.data;
              frame_start_next = s.sof;
            end
          end
        end
        default: state_next = ST_WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_WAIT_SOF;
      vsync_reg       <= ~VSYNC_POL;
      hsync_reg       <= ~HSYNC_POL;
      de_reg          <= 1'b0;
      data_reg        <= '0;
      frame_start_reg <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      vsync_reg       <= vsync_next;
      hsync_reg       <= hsync_next;
      de_reg          <= de_next;
      data_reg        <= data_next;
      frame_start_reg <= frame_start_next;
      underflow_reg   <= underflow_next;
    end
  end

  assign s.ready          = stream_ready;
  assign out_vsync        = vsync_reg;
  assign out_hsync        = hsync_reg;
  assign out_de           = de_reg;
  assign out_data         = data_reg;
  assign out_ctl          = 4'b0000;
  assign out_frame_start  = frame_start_reg;
  assign status_underflow = underflow_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a small 14x7 raster.
// Random stream scenarios are compared every cycle against a frame-position model.
module tb_video_timing_gen;

  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [32:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h0, 4'h0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset, enable, pat;
  logic out_vsync, out_hsync, out_de, out_frame_start, status_underflow;
  logic [23:0] out_data;
  logic [3:0]  out_ctl;

  video_timing_gen_if s_if();

  video_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
`ifdef VIDEO_TIMING_PATTERN_EN
    .pattern_sel      (pat),
`endif
    .s                (s_if),
    .out_vsync        (out_vsync),
    .out_hsync        (out_hsync),
    .out_de           (out_de),
    .out_data         (out_data),
    .out_ctl          (out_ctl),
    .out_frame_start  (out_frame_start),
    .status_underflow (status_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sof;
    logic [23:0] data;
  } word_t;

  word_t       src_q[$];
  bit          valid_gate;
  int          m_pos;
  bit          m_synced, m_uf;
  logic        exp_ready, got_ready;
  logic [32:0] exp_out, got_out;
  int          checks = 0;
  int          failures = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] bar_model(int h);
    int idx;
    logic [23:0] c;
    idx = h * 8 / HV;
    c[23:16] = (idx < 4) ? 8'hFF : 8'h00;
    c[15:8]  = ((idx % 4) < 2) ? 8'hFF : 8'h00;
    c[7:0]   = ((idx % 2) == 0) ? 8'hFF : 8'h00;
    return c;
  endfunction

  task automatic push_frame(input int words, input bit rnd, input int base);
    word_t w;
    for (int i = 0; i < words; i++) begin
      w.sof  = (i == 0);
      w.data = rnd ? 24'($urandom) : 24'(base + i);
      src_q.push_back(w);
    end
  endtask

  task automatic drive_inputs();
    if (src_q.size() > 0) begin
      s_if.valid = valid_gate;
      s_if.sof   = src_q[0].sof;
      s_if.data  = src_q[0].data;
    end else begin
      s_if.valid = 1'b0;
      s_if.sof   = 1'b0;
      s_if.data  = '0;
    end
  endtask

  // Frame position model: pixel (h,v) is just m_pos split by the line length.
  task automatic model_step();
    int h, v;
    bit act, org, valid, sof, hs, vs, de, fs;
    logic [23:0] d;
    valid = (s_if.valid === 1'b1);
    sof   = (s_if.sof === 1'b1);
    h = m_pos % HT;
    v = m_pos / HT;
    act = (h < HV) && (v < VV);
    org = (m_pos == 0);
    hs = !((h >= HV + HF) && (h < HV + HF + HS));
    vs = !((v >= VV + VF) && (v < VV + VF + VS));
    d = '0; fs = 1'b0; de = 1'b0; exp_ready = 1'b0;
    if (!enable) begin
      m_synced = 1'b0; m_uf = 1'b0; hs = 1'b1; vs = 1'b1; m_pos = 0;
    end else begin
      de = act;
      if (pat) begin
        m_synced = 1'b0;
        if (act) d = bar_model(h);
      end else if (!m_synced) begin
        exp_ready = valid && (!sof || org);
        if (act && org && valid && sof) begin
          d = s_if.data; fs = 1'b1; m_synced = 1'b1;
        end
      end else begin
        exp_ready = act && (!sof || org);
        if (act) begin
          if (!valid || (sof && !org)) begin
            m_uf = 1'b1; m_synced = 1'b0;
          end else begin
            d = s_if.data; fs = sof;
          end
        end
      end
      m_pos = (m_pos + 1) % FT;
    end
    if (exp_ready && valid) void'(src_q.pop_front());
    exp_out = {vs, hs, de, d, 4'h0, fs, m_uf};
  endtask

  task automatic cycle();
    drive_inputs();
    #2;
    got_ready = s_if.ready;
    model_step();
    @(posedge clk);
    #1;
    got_out = {out_vsync, out_hsync, out_de, out_data, out_ctl, out_frame_start, status_underflow};
  endtask

  task automatic realign();
    enable = 1'b0;
    valid_gate = 1'b0;
    src_q.delete();
    cycle();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pat = 1'b0; valid_gate = 1'b0;
    s_if.valid = 1'b0; s_if.sof = 1'b0; s_if.data = '0;
    @(posedge clk); #1;
    checks++;
    if ({out_vsync, out_hsync, out_de, out_data, out_ctl, out_frame_start, status_underflow} !== IDLE) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", {out_vsync, out_hsync, out_de, out_data, out_ctl, out_frame_start, status_underflow}, IDLE);
    end
    m_pos = 0; m_synced = 1'b0; m_uf = 1'b0;
    reset = 1'b0;
    realign();
    push_frame(32, 1, 0);
    valid_gate = 1'b1;
    for (int i = 0; i < 40; i++) begin
      valid_gate = (i != 20);
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL reset_run_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL reset_run_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_vsync, out_hsync, out_de, out_data, out_ctl, out_frame_start, status_underflow} !== IDLE) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", {out_vsync, out_hsync, out_de, out_data, out_ctl, out_frame_start, status_underflow}, IDLE);
    end
    m_pos = 0; m_synced = 1'b0; m_uf = 1'b0; src_q.delete(); enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_free_run();
    int de_cnt, hs_low, vs_low;
    de_cnt = 0; hs_low = 0; vs_low = 0;
    realign();
    for (int i = 0; i < 2 * FT; i++) begin
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL free_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL free_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
      de_cnt += int'(out_de);
      hs_low += int'(!out_hsync);
      vs_low += int'(!out_vsync);
    end
    checks++;
    if (de_cnt != 2 * HV * VV) begin failures++; $display("FAIL free_de_count got=%0d exp=%0d", de_cnt, 2 * HV * VV); end
    checks++;
    if (hs_low != 2 * HS * VT) begin failures++; $display("FAIL free_hsync_low got=%0d exp=%0d", hs_low, 2 * HS * VT); end
    checks++;
    if (vs_low != 2 * VS * HT) begin failures++; $display("FAIL free_vsync_low got=%0d exp=%0d", vs_low, 2 * VS * HT); end
    $display("test_free_run done de=%0d hsync_low=%0d vsync_low=%0d", de_cnt, hs_low, vs_low);
  endtask

  task automatic test_stream();
    int fs_cnt, last_fs;
    fs_cnt = 0; last_fs = -1;
    realign();
    for (int f = 0; f < 3; f++) push_frame(32, 0, 0);
    valid_gate = 1'b1;
    for (int i = 0; i < 3 * FT; i++) begin
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL stream_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
      if (out_frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != FT) begin failures++; $display("FAIL stream_fs_period got=%0d exp=%0d", i - last_fs, FT); end
        end
        last_fs = i;
        fs_cnt++;
      end
    end
    checks++;
    if (fs_cnt != 3) begin failures++; $display("FAIL stream_fs_count got=%0d exp=3", fs_cnt); end
    checks++;
    if (status_underflow !== 1'b0) begin failures++; $display("FAIL stream_no_underflow got=%b exp=0", status_underflow); end
    $display("test_stream done frame_starts=%0d", fs_cnt);
  endtask

  task automatic test_underflow(input int p);
    int drop_pos, fs_cnt;
    fs_cnt = 0;
    drop_pos = (p / HV) * HT + (p % HV);
    realign();
    push_frame(32, 1, 0);
    push_frame(32, 1, 0);
    for (int i = 0; i < 2 * FT; i++) begin
      valid_gate = (i != drop_pos);
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL underflow_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL underflow_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
      if (i == drop_pos) begin
        checks++;
        if (status_underflow !== 1'b1 || out_data !== 24'h0 || out_de !== 1'b1) begin
          failures++; $display("FAIL underflow_at_drop uf=%b data=%h de=%b exp uf=1 data=0 de=1", status_underflow, out_data, out_de);
        end
      end
      fs_cnt += int'(out_frame_start === 1'b1);
    end
    checks++;
    if (fs_cnt != 2 || status_underflow !== 1'b1) begin
      failures++; $display("FAIL underflow_resume fs=%0d uf=%b exp fs=2 uf=1", fs_cnt, status_underflow);
    end
    $display("test_underflow done pixel=%0d frame_starts=%0d", p, fs_cnt);
  endtask

  task automatic test_junk_start();
    int k, j, fs_at;
    logic [23:0] sof_data;
    word_t w;
    k = $urandom_range(3, 60);
    j = $urandom_range(1, 20);
    fs_at = -1;
    sof_data = '0;
    realign();
    valid_gate = 1'b1;
    for (int i = 0; i < 3 * FT; i++) begin
      if (i == k) begin
        for (int n = 0; n < j; n++) begin
          w.sof = 1'b0; w.data = 24'($urandom); src_q.push_back(w);
        end
        push_frame(32, 1, 0);
        sof_data = src_q[j].data;
      end
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL junk_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL junk_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
      if (fs_at < 0 && out_frame_start === 1'b1) begin
        fs_at = i;
        checks++;
        if (out_data !== sof_data || (i % FT) != 0) begin
          failures++; $display("FAIL junk_first_pixel data=%h pos=%0d exp data=%h pos=0", out_data, i % FT, sof_data);
        end
      end
    end
    checks++;
    if (fs_at < 0) begin failures++; $display("FAIL junk_no_frame_start got=none exp=one"); end
    $display("test_junk_start done junk=%0d start=%0d fs_cycle=%0d", j, k, fs_at);
  endtask

  task automatic test_misplaced_sof();
    logic [23:0] b_sof;
    realign();
    push_frame(5, 1, 0);
    push_frame(32, 1, 0);
    b_sof = src_q[5].data;
    valid_gate = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL missof_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL missof_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
      if (i == 5) begin
        checks++;
        if (status_underflow !== 1'b1 || out_data !== 24'h0) begin
          failures++; $display("FAIL missof_flag uf=%b data=%h exp uf=1 data=0", status_underflow, out_data);
        end
      end
      if (i == FT) begin
        checks++;
        if (out_frame_start !== 1'b1 || out_data !== b_sof) begin
          failures++; $display("FAIL missof_redisplay fs=%b data=%h exp fs=1 data=%h", out_frame_start, out_data, b_sof);
        end
      end
    end
    $display("test_misplaced_sof done sof_word=%h", b_sof);
  endtask

  task automatic test_enable_toggle();
    int cut, off_len, total;
    cut = 2 * HT + $urandom_range(0, HT - 1);
    off_len = $urandom_range(3, 20);
    total = cut + off_len + 2 * FT;
    realign();
    for (int f = 0; f < 3; f++) push_frame(32, 1, 0);
    for (int i = 0; i < total; i++) begin
      valid_gate = (i != 3);
      enable = !(i >= cut && i < cut + off_len);
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL enable_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL enable_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
      if (i == cut + off_len - 1) begin
        checks++;
        if (got_out !== IDLE) begin failures++; $display("FAIL enable_idle got=%h exp=%h", got_out, IDLE); end
      end
      if (i == cut + off_len) begin
        checks++;
        if (out_de !== 1'b1 || out_hsync !== 1'b1 || out_vsync !== 1'b1 || status_underflow !== 1'b0) begin
          failures++; $display("FAIL enable_restart de=%b hs=%b vs=%b uf=%b exp 1 1 1 0", out_de, out_hsync, out_vsync, status_underflow);
        end
      end
    end
    enable = 1'b1;
    $display("test_enable_toggle done cut=%0d off=%0d", cut, off_len);
  endtask

`ifdef VIDEO_TIMING_PATTERN_EN
  task automatic test_pattern();
    realign();
    push_frame(32, 1, 0);
    valid_gate = 1'b1;
    pat = 1'b1;
    for (int i = 0; i < FT; i++) begin
      cycle();
      checks++;
      if (got_ready !== exp_ready) begin failures++; $display("FAIL pattern_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("FAIL pattern_out cyc=%0d got=%h exp=%h", i, got_out, exp_out); end
      if (i == 0 || i == HV - 1) begin
        checks++;
        if (out_data !== ((i == 0) ? 24'hFFFFFF : 24'h000000)) begin
          failures++; $display("FAIL pattern_bar cyc=%0d got=%h", i, out_data);
        end
      end
    end
    pat = 1'b0;
    $display("test_pattern done");
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_stream();
    test_underflow(10);
    test_underflow($urandom_range(1, 31));
    test_junk_start();
    test_misplaced_sof();
    test_enable_toggle();
`ifdef VIDEO_TIMING_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
